// File: rtl/subtractor_6bits_serial_if.sv
// Handshake and data bundle for the 6-bit bit-serial subtractor.
// The slave side is the subtractor; the master side is whoever issues requests.
interface subtractor_6bits_serial_if;
    logic       i_w_start;
    logic [5:0] i_w_a;
    logic [5:0] i_w_b;
    logic       o_w_ready;
    logic       o_w_busy;
    logic       o_w_done;
    logic [6:0] o_w_d;

    modport slave (
        input  i_w_start,
        input  i_w_a,
        input  i_w_b,
        output o_w_ready,
        output o_w_busy,
        output o_w_done,
        output o_w_d
    );

    modport master (
        output i_w_start,
        output i_w_a,
        output i_w_b,
        input  o_w_ready,
        input  o_w_busy,
        input  o_w_done,
        input  o_w_d
    );
endinterface

// File: rtl/subtractor_6bits_serial.sv
// Bit-serial 6-bit unsigned subtractor: one full-subtractor step per clock, LSB first.
// Result is {borrow, (a-b) mod 64}, held until the next accepted start.
//
// state | meaning
// IDLE  | ready for a request, o_w_d holds the last result
// RUN   | one bit per edge, index 0..5
// DONE  | one-cycle completion pulse, then back to IDLE
module subtractor_6bits_serial (
    input  logic                            i_w_clk,
    input  logic                            i_w_rst_n,
    subtractor_6bits_serial_if.slave        io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [5:0] r_a;
    logic [5:0] r_b;
    logic       r_borrow;
    logic [2:0] r_idx;
    logic [6:0] r_d;

    logic       w_ready;
    logic       w_busy;
    logic       w_done;
    logic       w_last;
    logic [7:0] w_a_ext;
    logic [7:0] w_b_ext;
    logic       w_a_bit;
    logic       w_b_bit;
    logic       w_diff;
    logic       w_bout;
    logic [7:0] w_d_upd;

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Unused encoding falls through to default and returns to IDLE.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready     = 1'b1;
                w_state_nxt = io_bus.i_w_start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_busy      = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_last  = (r_idx >= 3'd5);
    assign w_a_ext = {2'b00, r_a};
    assign w_b_ext = {2'b00, r_b};
    assign w_a_bit = w_a_ext[r_idx];
    assign w_b_bit = w_b_ext[r_idx];
    assign w_diff  = w_a_bit ^ w_b_bit ^ r_borrow;
    assign w_bout  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);

    // Write the current difference bit; the final step also writes the borrow into bit 6.
    always_comb begin
        w_d_upd        = {1'b0, r_d};
        w_d_upd[r_idx] = w_diff;
        if (w_last) begin
            w_d_upd[6] = w_bout;
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            r_a      <= 6'd0;
            r_b      <= 6'd0;
            r_borrow <= 1'b0;
            r_idx    <= 3'd0;
            r_d      <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.i_w_start) begin
                        r_a      <= io_bus.i_w_a;
                        r_b      <= io_bus.i_w_b;
                        r_borrow <= 1'b0;
                        r_idx    <= 3'd0;
                        r_d      <= 7'd0;
                    end
                end
                S_RUN: begin
                    r_d      <= w_d_upd[6:0];
                    r_borrow <= w_bout;
                    r_idx    <= w_last ? 3'd0 : r_idx + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.o_w_ready = w_ready;
    assign io_bus.o_w_busy  = w_busy;
    assign io_bus.o_w_done  = w_done;
    assign io_bus.o_w_d     = r_d;

endmodule

// File: doc/subtractor_6bits_serial.md
SUBTRACTOR_6BITS_SERIAL -- requirements
Module: subtractor_6bits_serial

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 6 bits and the result width at 7 bits.
REQ-002 i_w_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 i_w_rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of i_w_clk.
REQ-004 i_w_start  input  1  request; accepted only when o_w_ready=1.
REQ-005 i_w_a  input  6  minuend, unsigned; sampled on the accepting edge.
REQ-006 i_w_b  input  6  subtrahend, unsigned; sampled on the accepting edge.
REQ-007 o_w_ready  output  1  high exactly when the block is in IDLE.
REQ-008 o_w_busy  output  1  high exactly when the block is in RUN.
REQ-009 o_w_done  output  1  single-cycle pulse; high exactly when the block is in DONE.
REQ-010 o_w_d  output  7  registered result. Bits [5:0] SHALL hold (a-b) mod 64. Bit [6] SHALL hold the final borrow, which is 1 iff a<b.

Function
REQ-011 The block SHALL have three states: IDLE, RUN and DONE.
REQ-012 In IDLE, if i_w_start=1 at a rising edge, the block SHALL do all of the following on that edge:
- latch i_w_a and i_w_b into internal operand registers;
- clear the borrow register;
- clear the 3-bit bit index;
- clear o_w_d to 0;
- enter RUN.
REQ-013 In IDLE with i_w_start=0, all state SHALL hold, including o_w_d, which keeps the previous result.
REQ-014 In RUN, each edge SHALL process exactly one bit i (LSB first, i=0..5) with a full-subtractor:
- d_i = a_i ^ b_i ^ bin;
- bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin);
- d_i is written to o_w_d[i];
- bout is stored as the next bin;
- the index is incremented.
REQ-015 On the edge that processes i=5, the block SHALL write the final bout to o_w_d[6] and enter DONE.
REQ-016 Exactly 6 RUN cycles SHALL occur per operation.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; o_w_done SHALL be high for that one cycle only.
REQ-018 Latency: if the start is accepted at edge E, o_w_done SHALL be high in the cycle following edge E+6, and o_w_d SHALL be complete and valid in that same cycle.
REQ-019 o_w_d SHALL remain stable from DONE until the next accepted start.
REQ-020 i_w_start SHALL be ignored in RUN and DONE: no restart, and no change to the latched operands.
REQ-021 A start asserted in the DONE cycle SHALL be ignored; a new start is accepted at the earliest on the edge ending the first IDLE cycle after DONE.
REQ-022 Changes on i_w_a and i_w_b after the accepting edge SHALL NOT affect the result.
REQ-023 Back-to-back operations SHALL be possible with i_w_start held high continuously: one operation every 8 cycles (accept, 6 RUN cycles, DONE, then re-accept from IDLE).
REQ-024 The index SHALL never exceed 5 in RUN, and unused index encodings (6, 7) SHALL NOT be reachable.
REQ-025 Any unreachable state encoding SHALL return the block to IDLE on the next edge.

Reset
REQ-026 When i_w_rst_n=0 at a rising edge, the block SHALL enter IDLE and clear to 0: operand registers, borrow, index, o_w_d, o_w_busy and o_w_done; o_w_ready SHALL be 1 in the cycle after that edge.
REQ-027 Reset SHALL take priority over i_w_start and over any in-progress RUN or DONE; an aborted operation SHALL produce no o_w_done pulse.
REQ-028 Reset SHALL have no asynchronous effect; outputs SHALL change only at a clock edge.

Verification
REQ-029 a=45, b=12, start pulsed -> o_w_busy high for 6 cycles, then o_w_done high 1 cycle with o_w_d=7'h21 (33, borrow 0).
REQ-030 a=12, b=45 -> o_w_d=7'h5F at o_w_done (low bits 31, borrow 1); a=0, b=1 -> o_w_d=7'h7F.
REQ-031 a=63, b=63 and a=0, b=0 -> o_w_d=7'h00 in both cases; exhaustive 64x64 sweep -> o_w_d matches {a<b, (a-b) mod 64} for every pair.
REQ-032 Start with a=45, b=12; during RUN drive i_w_start=1, a=1, b=2 -> start ignored, o_w_d=7'h21, exactly one o_w_done pulse.
REQ-033 Start, then assert i_w_rst_n=0 for 1 cycle during the 3rd RUN cycle -> IDLE, o_w_d=0, o_w_ready=1 next cycle, no o_w_done pulse; a subsequent operation computes correctly.
REQ-034 i_w_start held high with fixed operands -> o_w_done pulses exactly 8 cycles apart, each with the correct result.
